// File: rtl/duty_cycle_controller.sv
// rtl/duty_cycle_controller.sv - pushbutton-driven saturating duty-cycle register with debounce and auto-repeat

// Per-button 2-FF synchroniser plus stable-sample debouncer; level_next is the value level takes next cycle
module duty_cycle_debounce #(
    parameter int CYCLES = 100000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic level_next
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive samples disagreeing with the accepted level; flip after CYCLES of them
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser, counter and debounced level registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level      = level_q;
    assign level_next = level_d;
endmodule

module duty_cycle_controller #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter int DUTY_INIT       = 50,
    parameter int DUTY_MIN        = 0,
    parameter int DUTY_MAX        = 99,
    parameter int COARSE_STEP     = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       coarse,
    input  logic       load,
    input  logic [6:0] load_value,
    output logic [6:0] duty_cycle,
    output logic       changed,
    output logic       at_limit
);
    localparam int TMR_SPAN = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW       = (TMR_SPAN > 1) ? $clog2(TMR_SPAN) : 1;
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
    localparam logic [7:0] MIN8    = 8'(DUTY_MIN);
    localparam logic [7:0] MAX8    = 8'(DUTY_MAX);
    localparam logic [7:0] COARSE8 = 8'(COARSE_STEP);
    localparam logic [6:0] INIT7   = 7'(DUTY_INIT);
    localparam logic       INIT_AT_LIMIT = (DUTY_INIT == DUTY_MIN) || (DUTY_INIT == DUTY_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_HOLD,
        S_REPEAT,
        S_WAIT_REL
    } state_t;

    state_t        state_q, state_d;
    logic          dir_up_q, dir_up_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [6:0]    duty_q, duty_d;
    logic          changed_q, changed_d;
    logic          at_limit_q, at_limit_d;

    logic up_db, down_db;
    logic up_lvl, down_lvl;
    logic held, other;
    logic do_step;
    logic [7:0] step8, duty8, up_sum, up_val, down_val, step_val, load8, load_val;

    duty_cycle_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clock      (clock),
        .reset_n    (reset_n),
        .raw        (btn_up),
        .level      (up_db),
        .level_next (up_lvl)
    );

    duty_cycle_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clock      (clock),
        .reset_n    (reset_n),
        .raw        (btn_down),
        .level      (down_db),
        .level_next (down_lvl)
    );

    // Saturating step and load clamp, computed 8 bits wide so nothing can wrap
    always_comb begin
        step8    = coarse ? COARSE8 : 8'd1;
        duty8    = {1'b0, duty_q};
        up_sum   = duty8 + step8;
        up_val   = (up_sum > MAX8) ? MAX8 : up_sum;
        down_val = (duty8 < MIN8 + step8) ? MIN8 : duty8 - step8;
        step_val = dir_up_q ? up_val : down_val;
        load8    = {1'b0, load_value};
        if (load8 > MAX8) begin
            load_val = MAX8;
        end else if (load8 < MIN8) begin
            load_val = MIN8;
        end else begin
            load_val = load8;
        end
    end

    // Press / hold / repeat sequencing; decisions use the debounced level about to be registered
    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        timer_d  = timer_q;
        do_step  = 1'b0;
        held     = dir_up_q ? up_lvl : down_lvl;
        other    = dir_up_q ? down_lvl : up_lvl;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (up_lvl && down_lvl) begin
                    state_d = S_WAIT_REL;
                end else if (up_lvl ^ down_lvl) begin
                    state_d  = S_PRESS;
                    dir_up_d = up_lvl;
                end
            end
            S_PRESS: begin
                do_step = 1'b1;
                timer_d = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!held) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (other) begin
                    state_d = S_WAIT_REL;
                    timer_d = '0;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = S_REPEAT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_REPEAT: begin
                if (!held) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (other) begin
                    state_d = S_WAIT_REL;
                    timer_d = '0;
                end else if (timer_q == REPEAT_LAST) begin
                    do_step = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_REL: begin
                timer_d = '0;
                if (!up_lvl && !down_lvl) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Next duty value: load wins over a step; flags derive from the value being written
    always_comb begin
        duty_d = duty_q;
        if (load) begin
            duty_d = 7'(load_val);
        end else if (do_step) begin
            duty_d = 7'(step_val);
        end
        changed_d  = (duty_d != duty_q);
        at_limit_d = ({1'b0, duty_d} == MIN8) || ({1'b0, duty_d} == MAX8);
    end

    // State, timer and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dir_up_q   <= 1'b0;
            timer_q    <= '0;
            duty_q     <= INIT7;
            changed_q  <= 1'b0;
            at_limit_q <= INIT_AT_LIMIT;
        end else begin
            state_q    <= state_d;
            dir_up_q   <= dir_up_d;
            timer_q    <= timer_d;
            duty_q     <= duty_d;
            changed_q  <= changed_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign duty_cycle = duty_q;
    assign changed    = changed_q;
    assign at_limit   = at_limit_q;

    logic unused_db;
    assign unused_db = up_db ^ down_db;
endmodule

// File: tb/tb_duty_cycle_controller.sv
// tb/tb_duty_cycle_controller.sv - directed checks of duty_cycle_controller with short debounce/hold/repeat

module tb_duty_cycle_controller;
    logic       clock;
    logic       reset_n;
    logic       btn_up;
    logic       btn_down;
    logic       coarse;
    logic       load;
    logic [6:0] load_value;
    logic [6:0] duty_cycle;
    logic       changed;
    logic       at_limit;

    int n_checks = 0;
    int n_errors = 0;
    int chg_cnt  = 0;
    int c0;

    typedef struct {
        logic [6:0] value;
        logic [6:0] exp_duty;
        logic       exp_limit;
        logic       exp_changed;
    } load_vec_t;

    load_vec_t vecs[9];

    duty_cycle_controller #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (8),
        .DUTY_INIT       (50),
        .DUTY_MIN        (0),
        .DUTY_MAX        (99),
        .COARSE_STEP     (10)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .coarse     (coarse),
        .load       (load),
        .load_value (load_value),
        .duty_cycle (duty_cycle),
        .changed    (changed),
        .at_limit   (at_limit)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        #2;
        if (changed === 1'b1) chg_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_load(input logic [6:0] v);
        load       = 1'b1;
        load_value = v;
        cycles(1);
        load       = 1'b0;
    endtask

    initial begin
        vecs[0] = '{7'd50,  7'd50, 1'b0, 1'b0};
        vecs[1] = '{7'd0,   7'd0,  1'b1, 1'b1};
        vecs[2] = '{7'd120, 7'd99, 1'b1, 1'b1};
        vecs[3] = '{7'd99,  7'd99, 1'b1, 1'b0};
        vecs[4] = '{7'd127, 7'd99, 1'b1, 1'b0};
        vecs[5] = '{7'd98,  7'd98, 1'b0, 1'b1};
        vecs[6] = '{7'd1,   7'd1,  1'b0, 1'b1};
        vecs[7] = '{7'd100, 7'd99, 1'b1, 1'b1};
        vecs[8] = '{7'd50,  7'd50, 1'b0, 1'b1};

        reset_n    = 1'b0;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        coarse     = 1'b0;
        load       = 1'b0;
        load_value = 7'd0;
        cycles(2);
        check("reset_duty", duty_cycle, 50);
        check("reset_changed", changed, 0);
        check("reset_at_limit", at_limit, 0);

        reset_n = 1'b1;
        c0 = chg_cnt;
        cycles(50);
        check("idle_duty", duty_cycle, 50);
        check("idle_at_limit", at_limit, 0);
        check("idle_no_changed", chg_cnt - c0, 0);

        for (int i = 0; i < 9; i++) begin
            load       = 1'b1;
            load_value = vecs[i].value;
            cycles(1);
            load = 1'b0;
            check($sformatf("load%0d_duty", i), duty_cycle, vecs[i].exp_duty);
            check($sformatf("load%0d_limit", i), at_limit, vecs[i].exp_limit);
            check($sformatf("load%0d_changed", i), changed, vecs[i].exp_changed);
            cycles(1);
        end

        // bounce: 1-cycle pulse, then 3 cycles high, never accepted
        c0 = chg_cnt;
        btn_up = 1'b1; cycles(1);
        btn_up = 1'b0; cycles(2);
        btn_up = 1'b1; cycles(3);
        btn_up = 1'b0; cycles(10);
        check("bounce_duty", duty_cycle, 50);
        check("bounce_no_changed", chg_cnt - c0, 0);

        // clean press held 10 cycles: step lands 7 edges after the rise
        c0 = chg_cnt;
        btn_up = 1'b1;
        cycles(6);
        check("press_before", duty_cycle, 50);
        cycles(1);
        check("press_step", duty_cycle, 51);
        check("press_changed", changed, 1);
        cycles(3);
        btn_up = 1'b0;
        cycles(10);
        check("press_after_release", duty_cycle, 51);
        check("press_one_pulse", chg_cnt - c0, 1);

        // coarse down with auto-repeat: steps at edges 7, 35, 43, 51
        do_load(7'd50);
        coarse = 1'b1;
        c0 = chg_cnt;
        btn_down = 1'b1;
        cycles(6);  check("cdn_e6", duty_cycle, 50);
        cycles(1);  check("cdn_e7", duty_cycle, 40);
        cycles(27); check("cdn_e34", duty_cycle, 40);
        cycles(1);  check("cdn_e35", duty_cycle, 30);
        cycles(7);  check("cdn_e42", duty_cycle, 30);
        cycles(1);  check("cdn_e43", duty_cycle, 20);
        cycles(8);  check("cdn_e51", duty_cycle, 10);
        btn_down = 1'b0;
        cycles(12);
        check("cdn_final", duty_cycle, 10);
        check("cdn_pulses", chg_cnt - c0, 4);

        // upper saturation from 95 with coarse step
        do_load(7'd95);
        check("sat_hi_load_limit", at_limit, 0);
        c0 = chg_cnt;
        btn_up = 1'b1;
        cycles(7);
        check("sat_hi_step", duty_cycle, 99);
        check("sat_hi_limit", at_limit, 1);
        cycles(50);
        check("sat_hi_hold", duty_cycle, 99);
        check("sat_hi_limit_hold", at_limit, 1);
        check("sat_hi_pulses", chg_cnt - c0, 1);
        btn_up = 1'b0;
        cycles(8);

        // lower saturation: 5 - 10 clamps to 0
        do_load(7'd5);
        btn_down = 1'b1;
        cycles(7);
        check("sat_lo_step", duty_cycle, 0);
        check("sat_lo_limit", at_limit, 1);
        btn_down = 1'b0;
        cycles(8);
        coarse = 1'b0;

        // both buttons together: no step until both released
        do_load(7'd50);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        cycles(10);
        check("both_no_step", duty_cycle, 50);
        btn_down = 1'b0;
        cycles(10);
        check("both_down_released", duty_cycle, 50);
        btn_up = 1'b0;
        cycles(8);
        btn_up = 1'b1;
        cycles(7);
        check("both_fresh_press", duty_cycle, 51);
        btn_up = 1'b0;
        cycles(8);

        // load colliding with a due repeat step, then reset mid-repeat
        btn_down = 1'b1;
        cycles(7);
        check("lr_first_step", duty_cycle, 50);
        cycles(27);
        load       = 1'b1;
        load_value = 7'd120;
        cycles(1);
        load = 1'b0;
        check("lr_load_wins", duty_cycle, 99);
        check("lr_load_changed", changed, 1);
        cycles(8);
        check("lr_next_repeat", duty_cycle, 98);
        cycles(3);
        reset_n = 1'b0;
        #1;
        check("rst_mid_duty", duty_cycle, 50);
        check("rst_mid_changed", changed, 0);
        check("rst_mid_limit", at_limit, 0);
        cycles(2);
        reset_n = 1'b1;
        cycles(6);
        check("rst_redebounce_wait", duty_cycle, 50);
        cycles(1);
        check("rst_fresh_press", duty_cycle, 49);
        btn_down = 1'b0;
        cycles(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
